// File: rtl/tri_mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tri_mux_arb_pkg
// Description : Shared types and constants for the two-requester tristate
//               mux arbiter: FSM state encoding and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package tri_mux_arb_pkg;

    // Arbiter FSM states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    // Largest legal MAX_HOLD and TURN_CYCLES values; the counters are sized
    // so that any legal setting fits without per-instance width tweaks.
    localparam int c_MAX_HOLD_LIMIT = 255;
    localparam int c_TURN_LIMIT     = 15;
    localparam int c_HOLD_W         = $clog2(c_MAX_HOLD_LIMIT + 1);
    localparam int c_TURN_W         = $clog2(c_TURN_LIMIT + 1);

endpackage : tri_mux_arb_pkg
`default_nettype wire

// File: rtl/tri_mux_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : tri_mux_hold_timer
// Description : Saturating up-counter used for both the ownership hold time
//               and the bus-off turnaround time. load restarts at 1, enable
//               advances until LIMIT, at_limit flags count == LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_mux_hold_timer
    import tri_mux_arb_pkg::*;
#(
    parameter int WIDTH = c_HOLD_W,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Load has priority; counting stops at the limit so the flag stays up
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_ONE;
        end else if (enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count    = r_count;
    assign at_limit = (r_count == c_LIMIT);

endmodule : tri_mux_hold_timer
`default_nettype wire

// File: rtl/tri_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tri_mux_arbiter
// Description : Round-robin arbiter for two requesters sharing a 2:1
//               tristate mux. Owners are limited to MAX_HOLD cycles while
//               the other side waits, and every hand-over inserts
//               TURN_CYCLES bus-off cycles. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_mux_arbiter
    import tri_mux_arb_pkg::*;
#(
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       mux_e,
    output logic       mux_s,
    output logic       busy
);

    arb_state_t          r_state;
    logic [1:0]          r_gnt;
    logic                r_mux_e;
    logic                r_mux_s;
    logic                r_busy;
    logic                r_last_owner;

    logic [c_HOLD_W-1:0] w_hold_cnt;
    logic                w_hold_at_limit;
    logic [c_TURN_W-1:0] w_turn_cnt;
    logic                w_turn_at_limit;

    logic                w_any_req;
    logic                w_winner;
    logic                w_start;
    logic                w_leave;

    // Round robin: a lone requester wins, a tie goes to whoever did not own last
    assign w_any_req = |req;
    assign w_winner  = (&req) ? ~r_last_owner : req[1];

    // r_mux_s is the owner index while in OWN
    assign w_leave = (r_state == OWN) &&
                     (!req[r_mux_s] || (w_hold_at_limit && req[~r_mux_s]));

    // New ownership starts from IDLE or on the final turnaround cycle
    assign w_start = w_any_req &&
                     ((r_state == IDLE) || ((r_state == TURN) && w_turn_at_limit));

    tri_mux_hold_timer #(
        .WIDTH (c_HOLD_W),
        .LIMIT (MAX_HOLD)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_start),
        .enable   (r_state == OWN),
        .count    (w_hold_cnt),
        .at_limit (w_hold_at_limit)
    );

    tri_mux_hold_timer #(
        .WIDTH (c_TURN_W),
        .LIMIT (TURN_CYCLES)
    ) u_turn_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_leave),
        .enable   (r_state == TURN),
        .count    (w_turn_cnt),
        .at_limit (w_turn_at_limit)
    );

    // State and registered outputs; mux_s is only rewritten on a new grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= 2'b00;
            r_mux_e      <= 1'b0;
            r_mux_s      <= 1'b0;
            r_busy       <= 1'b0;
            r_last_owner <= 1'b1;
        end else if (w_start) begin
            r_state      <= OWN;
            r_gnt        <= w_winner ? 2'b10 : 2'b01;
            r_mux_e      <= 1'b1;
            r_mux_s      <= w_winner;
            r_busy       <= 1'b1;
            r_last_owner <= w_winner;
        end else begin
            case (r_state)
                OWN: begin
                    if (w_leave) begin
                        r_state <= TURN;
                        r_gnt   <= 2'b00;
                        r_mux_e <= 1'b0;
                    end
                end
                TURN: begin
                    if (w_turn_at_limit) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 2'b00;
                    r_mux_e <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the registered state
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_gnt != 2'b11);
            assert (!r_mux_e || (r_gnt != 2'b00));
            assert ((r_state != OWN)  || (w_hold_cnt != '0));
            assert ((r_state != TURN) || (w_turn_cnt != '0));
        end
    end

    assign gnt   = r_gnt;
    assign mux_e = r_mux_e;
    assign mux_s = r_mux_s;
    assign busy  = r_busy;

endmodule : tri_mux_arbiter
`default_nettype wire

// File: tb/tb_tri_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tri_mux_arbiter
// Description : Self-checking bench for tri_mux_arbiter. Two instances
//               (default timing, and MAX_HOLD=4/TURN_CYCLES=3) are compared
//               every cycle against an ownership-level reference model,
//               with directed scenarios followed by random requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_mux_arbiter;

    localparam int MH_A = 8;
    localparam int TC_A = 1;
    localparam int MH_B = 4;
    localparam int TC_B = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_a = 2'b00;
    logic [1:0] req_b = 2'b00;
    logic [1:0] gnt_a, gnt_b;
    logic       mux_e_a, mux_s_a, busy_a;
    logic       mux_e_b, mux_s_b, busy_b;

    int total = 0;
    int bad   = 0;
    int wait_a [2];
    int wait_b [2];
    int maxw_a = 0;
    int maxw_b = 0;

    always #5 clk = ~clk;

    tri_mux_arbiter #(.MAX_HOLD(MH_A), .TURN_CYCLES(TC_A)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a),
        .mux_e(mux_e_a), .mux_s(mux_s_a), .busy(busy_a)
    );

    tri_mux_arbiter #(.MAX_HOLD(MH_B), .TURN_CYCLES(TC_B)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b),
        .mux_e(mux_e_b), .mux_s(mux_s_b), .busy(busy_b)
    );

    // Reference model: who owns the mux, how long they have held it,
    // how many bus-off cycles remain before anyone may own it again.
    typedef struct {
        int owner;   // -1 when nobody owns the mux
        int last;
        int held;
        int off;
        int sel;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.owner = -1; m.last = 1; m.held = 0; m.off = 0; m.sel = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_grant(mdl_t m, logic [1:0] r);
        int w;
        w = (r == 2'b11) ? 1 - m.last : (r[1] ? 1 : 0);
        m.owner = w; m.last = w; m.sel = w; m.held = 1; m.off = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic [1:0] r, int mh, int tc);
        if (m.owner >= 0) begin
            if (!r[m.owner] || (m.held >= mh && r[1 - m.owner])) begin
                m.owner = -1;
                m.off   = tc;
            end else if (m.held < mh) begin
                m.held++;
            end
        end else if (m.off > 1) begin
            m.off--;
        end else if (r != 2'b00) begin
            m = mdl_grant(m, r);
        end else begin
            m.off = 0;
        end
        return m;
    endfunction

    function automatic logic [1:0] exp_gnt(mdl_t m);
        if (m.owner < 0) return 2'b00;
        return (m.owner == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic track_wait(input logic [1:0] r, input logic [1:0] g,
                              inout int w0, inout int w1, inout int mx);
        if (r[0] && !g[0]) w0++; else w0 = 0;
        if (r[1] && !g[1]) w1++; else w1 = 0;
        if (w0 > mx) mx = w0;
        if (w1 > mx) mx = w1;
    endtask

    // Apply inputs for one cycle, advance the model, compare every output
    task automatic step(input logic [1:0] ra, input logic [1:0] rb, input logic r);
        req_a = ra; req_b = rb; rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            ma = mdl_reset(); mb = mdl_reset();
            wait_a[0] = 0; wait_a[1] = 0; wait_b[0] = 0; wait_b[1] = 0;
        end else begin
            ma = mdl_step(ma, ra, MH_A, TC_A);
            mb = mdl_step(mb, rb, MH_B, TC_B);
            track_wait(ra, gnt_a, wait_a[0], wait_a[1], maxw_a);
            track_wait(rb, gnt_b, wait_b[0], wait_b[1], maxw_b);
        end
        check("a_gnt",   {6'd0, gnt_a},   {6'd0, exp_gnt(ma)});
        check("a_mux_e", {7'd0, mux_e_a}, {7'd0, ma.owner >= 0});
        check("a_mux_s", {7'd0, mux_s_a}, 8'(ma.sel));
        check("a_busy",  {7'd0, busy_a},  {7'd0, (ma.owner >= 0) || (ma.off > 0)});
        check("b_gnt",   {6'd0, gnt_b},   {6'd0, exp_gnt(mb)});
        check("b_mux_e", {7'd0, mux_e_b}, {7'd0, mb.owner >= 0});
        check("b_mux_s", {7'd0, mux_s_b}, 8'(mb.sel));
        check("b_busy",  {7'd0, busy_b},  {7'd0, (mb.owner >= 0) || (mb.off > 0)});
    endtask

    initial begin
        logic [1:0] ra, rb;
        int pos;
        logic [1:0] exp_seq;

        ma = mdl_reset(); mb = mdl_reset();
        wait_a[0] = 0; wait_a[1] = 0; wait_b[0] = 0; wait_b[1] = 0;

        // Reset state
        step(2'b00, 2'b00, 1'b1);
        step(2'b00, 2'b00, 1'b1);
        check("rst_gnt",  {6'd0, gnt_a}, 8'h00);
        check("rst_mux_s", {7'd0, mux_s_a}, 8'h00);
        check("rst_busy", {7'd0, busy_a}, 8'h00);

        // Single request, release, one turnaround cycle, then idle
        step(2'b01, 2'b00, 1'b0);
        check("single_gnt", {6'd0, gnt_a}, 8'h01);
        check("single_mux_e", {7'd0, mux_e_a}, 8'h01);
        step(2'b00, 2'b00, 1'b0);
        check("release_turn_mux_e", {7'd0, mux_e_a}, 8'h00);
        check("release_turn_busy", {7'd0, busy_a}, 8'h01);
        step(2'b00, 2'b00, 1'b0);
        check("release_idle_busy", {7'd0, busy_a}, 8'h00);

        // Both requesting from reset: 8 own, 1 off, alternating, 0 first
        step(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(2'b11, 2'b00, 1'b0);
            pos = i % 18;
            if (pos < 8)       exp_seq = 2'b01;
            else if (pos == 8) exp_seq = 2'b00;
            else if (pos < 17) exp_seq = 2'b10;
            else               exp_seq = 2'b00;
            check("rr_seq", {6'd0, gnt_a}, {6'd0, exp_seq});
        end

        // Lone requester keeps the mux past MAX_HOLD, preempted when 0 appears
        step(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(2'b10, 2'b00, 1'b0);
            check("lone_hold", {6'd0, gnt_a}, 8'h02);
        end
        step(2'b11, 2'b00, 1'b0);
        check("preempt_off", {6'd0, gnt_a}, 8'h00);
        step(2'b11, 2'b00, 1'b0);
        check("preempt_new", {6'd0, gnt_a}, 8'h01);

        // Reset in the middle of ownership
        step(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 1'b0);
        step(2'b11, 2'b00, 1'b1);
        check("midown_rst_gnt", {6'd0, gnt_a}, 8'h00);
        check("midown_rst_mux_e", {7'd0, mux_e_a}, 8'h00);
        step(2'b11, 2'b00, 1'b0);
        check("after_rst_gnt", {6'd0, gnt_a}, 8'h01);

        // Three-cycle turnaround on instance B
        step(2'b00, 2'b00, 1'b1);
        step(2'b00, 2'b01, 1'b0);
        check("b_own0", {6'd0, gnt_b}, 8'h01);
        for (int i = 0; i < TC_B; i++) begin
            step(2'b00, 2'b10, 1'b0);
            check("b_turn_mux_e", {7'd0, mux_e_b}, 8'h00);
            check("b_turn_mux_s", {7'd0, mux_s_b}, 8'h00);
        end
        step(2'b00, 2'b10, 1'b0);
        check("b_own1_gnt", {6'd0, gnt_b}, 8'h02);
        check("b_own1_mux_s", {7'd0, mux_s_b}, 8'h01);

        // Random requests with persistence and the occasional reset
        step(2'b00, 2'b00, 1'b1);
        maxw_a = 0; maxw_b = 0;
        ra = 2'b00; rb = 2'b00;
        for (int i = 0; i < 10000; i++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(3) == 0) ra[b] = ~ra[b];
                if ($urandom_range(3) == 0) rb[b] = ~rb[b];
            end
            step(ra, rb, ($urandom_range(999) == 0));
        end
        check("a_wait_bound", {7'd0, maxw_a <= 2 * (MH_A + TC_A) + 1}, 8'h01);
        check("b_wait_bound", {7'd0, maxw_b <= 2 * (MH_B + TC_B) + 1}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tri_mux_arbiter
`default_nettype wire

// File: doc/tri_mux_arbiter.md
TRI_MUX_ARBITER -- requirements
Module: tri_mux_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum OWN cycles while the other requester waits; legal range 1..255.
REQ-002 The block SHALL have parameter TURN_CYCLES, default 1, giving the bus-off cycles between owners; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, 2 bits: req[i] high means requester i wants the shared 2:1 tristate mux output.
REQ-006 The block SHALL have port gnt, output, 2 bits: one-hot or zero, naming the current owner.
REQ-007 The block SHALL have port mux_e, output, 1 bit: enable to the tristate 2:1 mux; output high-Z when low.
REQ-008 The block SHALL have port mux_s, output, 1 bit: select to the mux; equals the owner index.
REQ-009 The block SHALL have port busy, output, 1 bit: high in OWN or TURN.

Function
REQ-010 The block SHALL implement the states IDLE, OWN and TURN.
REQ-011 In IDLE with req!=0, the block SHALL enter OWN at the next edge, so gnt and mux_e rise one cycle after req is first sampled.
REQ-012 Arbitration SHALL be round-robin: if one request is present, that requester wins; if both are present, requester !last_owner wins; last_owner updates on each entry to OWN.
REQ-013 In OWN: gnt[owner]=1, mux_e=1, mux_s=owner; the hold counter SHALL count from 1 and saturate at MAX_HOLD.
REQ-014 In OWN, if req[owner]=0, the block SHALL enter TURN at the next edge.
REQ-015 In OWN, if the hold counter equals MAX_HOLD and req[!owner]=1, the block SHALL preempt the owner and enter TURN at the next edge.
REQ-016 If the hold counter has saturated and no competitor is requesting, the owner SHALL keep the mux indefinitely.
REQ-017 In TURN: gnt=0 and mux_e=0; mux_s SHALL hold its last value; TURN SHALL last exactly TURN_CYCLES cycles.
REQ-018 On the last TURN cycle, the block SHALL arbitrate per REQ-012: with req!=0 it goes directly to OWN, otherwise to IDLE.
REQ-019 In IDLE: gnt=0, mux_e=0, busy=0, and mux_s SHALL hold its value.
REQ-020 gnt SHALL never be 2'b11; mux_e=1 SHALL imply gnt!=0; ownership SHALL never change without at least TURN_CYCLES cycles with mux_e=0 between owners.
REQ-021 All outputs SHALL be registered, with no combinational path from req to any output.

Reset
REQ-022 When rst=1 at an edge, the block SHALL set state=IDLE, gnt=0, mux_e=0, mux_s=0, busy=0, hold counter=0, TURN counter=0 and last_owner=1, regardless of current state, including mid-OWN or mid-TURN.
REQ-023 The first arbitration after reset SHALL favour requester 0 when both requests are present.

Structure
REQ-024 Package tri_mux_arb_pkg SHALL hold the state enum (IDLE, OWN, TURN) and the counter-width constants derived from MAX_HOLD and TURN_CYCLES.
REQ-025 The hold counter and TURN counter SHALL be implemented in one sub-module, tri_mux_hold_timer, with ports load, enable, count and at_limit.
REQ-026 The expected RTL size is 150-250 lines.

Verification
REQ-027 After reset, req=01 -> at the next edge gnt=01, mux_e=1, mux_s=0; req then drops -> 1 TURN cycle with mux_e=0, then IDLE.
REQ-028 With last_owner=1 after reset and req=11 held -> gnt sequence 01 (8 cycles), 00 (1), 10 (8), 00 (1), 01 ... with MAX_HOLD=8.
REQ-029 req=10 held for 20 cycles alone -> gnt=10 continuously; at cycle 12 req[0] rises -> gnt=00 at the next edge, then 01.
REQ-030 With TURN_CYCLES=3, owner 0 releases while req[1]=1 -> exactly 3 cycles with mux_e=0, mux_s=0, then gnt=10 and mux_s=1.
REQ-031 rst=1 asserted on the 4th OWN cycle -> all outputs 0 at the next edge; with rst released and req=11 -> gnt=01.
REQ-032 Random req for 10k cycles -> assertions for REQ-020 and REQ-021 never fire, and every request is granted within 2*(MAX_HOLD+TURN_CYCLES)+1 cycles.
